// File: rtl/snake_core_if.sv
// Bus bundle between the snake core and its environment: control pulses, apple position, pixel query and game status.
interface snake_core_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int LEN_W = 6
);
    logic             start;
    logic             step;
    logic [3:0]       dir_req;
    logic [X_W-1:0]   apple_x;
    logic [Y_W-1:0]   apple_y;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic             pix_head;
    logic             pix_body;
    logic             eaten;
    logic             game_over;
    logic             busy;
    logic [LEN_W-1:0] length;
    logic [X_W-1:0]   head_x;
    logic [Y_W-1:0]   head_y;

    modport master (
        output start, step, dir_req, apple_x, apple_y, pix_x, pix_y,
        input  pix_head, pix_body, eaten, game_over, busy, length, head_x, head_y
    );

    modport slave (
        input  start, step, dir_req, apple_x, apple_y, pix_x, pix_y,
        output pix_head, pix_body, eaten, game_over, busy, length, head_x, head_y
    );
endinterface

// File: rtl/snake_core_engine.sv
// Snake game core: segment store, direction filter, step/collision FSM and per-pixel head/body query.
// Optional feature macro WRAP_AROUND_EN: border exit wraps to the opposite limit instead of killing the snake.
module snake_core_engine #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int CELL    = 3,
    parameter int X_MIN   = 5,
    parameter int X_MAX   = 153,
    parameter int Y_MIN   = 5,
    parameter int Y_MAX   = 105,
    parameter int START_X = 80,
    parameter int START_Y = 60
) (
    input  logic        i_clk,
    input  logic        i_reset,
    snake_core_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_MOVE  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DEAD  = 3'd4;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [X_W:0]     LX_CELL = (X_W+1)'(CELL);
    localparam logic [X_W:0]     LX_MIN  = (X_W+1)'(X_MIN);
    localparam logic [X_W:0]     LX_MAX  = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0]     LY_CELL = (Y_W+1)'(CELL);
    localparam logic [Y_W:0]     LY_MIN  = (Y_W+1)'(Y_MIN);
    localparam logic [Y_W:0]     LY_MAX  = (Y_W+1)'(Y_MAX);
    localparam logic [X_W-1:0]   SX      = X_W'(START_X);
    localparam logic [Y_W-1:0]   SY      = Y_W'(START_Y);
    localparam logic [X_W-1:0]   WX_MIN  = X_W'(X_MIN);
    localparam logic [X_W-1:0]   WX_MAX  = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   WY_MIN  = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0]   WY_MAX  = Y_W'(Y_MAX);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_TOP = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

`ifdef WRAP_AROUND_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    function automatic logic is_onehot(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[1], d[0], d[3], d[2]};
    endfunction

    function automatic logic in_cell_x(input logic [X_W-1:0] p, input logic [X_W-1:0] s);
        return (p >= s) && ({1'b0, p} < ({1'b0, s} + LX_CELL));
    endfunction

    function automatic logic in_cell_y(input logic [Y_W-1:0] p, input logic [Y_W-1:0] s);
        return (p >= s) && ({1'b0, p} < ({1'b0, s} + LY_CELL));
    endfunction

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [X_W-1:0]   r_seg_x [MAX_LEN];
    logic [Y_W-1:0]   r_seg_y [MAX_LEN];
    logic             r_hx_oob;
    logic             r_hy_oob;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [3:0]       r_cur_dir;
    logic [3:0]       r_next_dir;
    logic             r_eaten;
    logic             r_busy;
    logic             r_game_over;
    logic             r_pix_head;
    logic             r_pix_body;

    logic [X_W:0]     w_hx_ext;
    logic [Y_W:0]     w_hy_ext;
    logic [X_W-1:0]   w_hx_new;
    logic [Y_W-1:0]   w_hy_new;
    logic             w_dir_ok;
    logic             w_active;
    logic             w_border_hit;
    logic             w_self_hit;
    logic             w_chk_hit;
    logic             w_last;
    logic             w_apple_hit;
    logic             w_body_hit;

    // Head step arithmetic, one bit wider so a move past zero shows up as out of range.
    always_comb begin
        w_hx_ext = {1'b0, r_seg_x[0]};
        w_hy_ext = {1'b0, r_seg_y[0]};
        case (r_cur_dir)
            DIR_RIGHT: w_hx_ext = {1'b0, r_seg_x[0]} + LX_CELL;
            DIR_LEFT:  w_hx_ext = {1'b0, r_seg_x[0]} - LX_CELL;
            DIR_DOWN:  w_hy_ext = {1'b0, r_seg_y[0]} + LY_CELL;
            DIR_UP:    w_hy_ext = {1'b0, r_seg_y[0]} - LY_CELL;
            default:   w_hx_ext = {1'b0, r_seg_x[0]};
        endcase
    end

    // New head position; in wrap mode a border exit re-enters at the opposite limit.
    always_comb begin
        w_hx_new = w_hx_ext[X_W-1:0];
        w_hy_new = w_hy_ext[Y_W-1:0];
        if (WRAP && (r_cur_dir == DIR_LEFT) && (w_hx_ext[X_W] || (w_hx_ext < LX_MIN))) begin
            w_hx_new = WX_MAX;
        end else if (WRAP && (r_cur_dir == DIR_RIGHT) && (w_hx_ext > LX_MAX)) begin
            w_hx_new = WX_MIN;
        end else begin
            w_hx_new = w_hx_ext[X_W-1:0];
        end
        if (WRAP && (r_cur_dir == DIR_UP) && (w_hy_ext[Y_W] || (w_hy_ext < LY_MIN))) begin
            w_hy_new = WY_MAX;
        end else if (WRAP && (r_cur_dir == DIR_DOWN) && (w_hy_ext > LY_MAX)) begin
            w_hy_new = WY_MIN;
        end else begin
            w_hy_new = w_hy_ext[Y_W-1:0];
        end
    end

    // Direction filter, collision terms and the body pixel scan.
    always_comb begin
        w_active     = (r_state == ST_RUN) || (r_state == ST_MOVE) || (r_state == ST_CHECK);
        w_dir_ok     = is_onehot(bus.dir_req) && (bus.dir_req != opposite(r_cur_dir));
        w_border_hit = ({r_hx_oob, r_seg_x[0]} < LX_MIN) || ({r_hx_oob, r_seg_x[0]} > LX_MAX) ||
                       ({r_hy_oob, r_seg_y[0]} < LY_MIN) || ({r_hy_oob, r_seg_y[0]} > LY_MAX);
        w_self_hit   = (r_seg_x[r_idx[IDX_W-1:0]] == r_seg_x[0]) &&
                       (r_seg_y[r_idx[IDX_W-1:0]] == r_seg_y[0]);
        w_chk_hit    = (r_idx == LEN_ZERO) ? (w_border_hit && !WRAP) : w_self_hit;
        w_last       = (r_idx == (r_len - LEN_ONE));
        w_apple_hit  = (r_seg_x[0] == bus.apple_x) && (r_seg_y[0] == bus.apple_y);
        w_body_hit   = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            w_body_hit = w_body_hit | ((LEN_W'(i) < r_len) &&
                         in_cell_x(bus.pix_x, r_seg_x[i]) && in_cell_y(bus.pix_y, r_seg_y[i]));
        end
    end

    // Game FSM next state; CHECK index 0 is the border test, 1..length-1 the self scan.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:   w_state_nxt = bus.step ? ST_MOVE : ST_RUN;
            ST_MOVE:  w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (w_chk_hit) begin
                    w_state_nxt = ST_DEAD;
                end else if (w_last) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_DEAD:  w_state_nxt = bus.start ? ST_RUN : ST_DEAD;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, segment store, direction latches and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= SX;
                r_seg_y[i] <= SY;
            end
            r_hx_oob    <= 1'b0;
            r_hy_oob    <= 1'b0;
            r_len       <= LEN_ZERO;
            r_idx       <= LEN_ZERO;
            r_cur_dir   <= DIR_RIGHT;
            r_next_dir  <= DIR_RIGHT;
            r_eaten     <= 1'b0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            r_pix_head  <= 1'b0;
            r_pix_body  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == ST_MOVE) || (w_state_nxt == ST_CHECK);
            r_game_over <= (w_state_nxt == ST_DEAD);
            r_eaten     <= 1'b0;
            r_pix_head  <= (r_state != ST_IDLE) &&
                           in_cell_x(bus.pix_x, r_seg_x[0]) && in_cell_y(bus.pix_y, r_seg_y[0]);
            r_pix_body  <= (r_state != ST_IDLE) && w_body_hit;
            if (w_active && w_dir_ok) begin
                r_next_dir <= bus.dir_req;
            end
            case (r_state)
                ST_IDLE, ST_DEAD: begin
                    if (bus.start) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            r_seg_x[i] <= SX;
                            r_seg_y[i] <= SY;
                        end
                        r_hx_oob   <= 1'b0;
                        r_hy_oob   <= 1'b0;
                        r_len      <= LEN_ONE;
                        r_cur_dir  <= DIR_RIGHT;
                        r_next_dir <= DIR_RIGHT;
                    end
                end
                ST_RUN: begin
                    if (bus.step) begin
                        r_cur_dir <= r_next_dir;
                    end
                end
                ST_MOVE: begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    r_seg_x[0] <= w_hx_new;
                    r_seg_y[0] <= w_hy_new;
                    r_hx_oob   <= w_hx_ext[X_W] && !WRAP;
                    r_hy_oob   <= w_hy_ext[Y_W] && !WRAP;
                    r_idx      <= LEN_ZERO;
                end
                ST_CHECK: begin
                    if (!w_chk_hit) begin
                        if (w_last) begin
                            // The shift already copied the old tail into seg[length], so growth is immediate.
                            if (w_apple_hit) begin
                                r_eaten <= 1'b1;
                                if (r_len != LEN_TOP) begin
                                    r_len <= r_len + LEN_ONE;
                                end
                            end
                        end else begin
                            r_idx <= r_idx + LEN_ONE;
                        end
                    end
                end
                default: r_idx <= LEN_ZERO;
            endcase
        end
    end

    assign bus.pix_head  = r_pix_head;
    assign bus.pix_body  = r_pix_body;
    assign bus.eaten     = r_eaten;
    assign bus.game_over = r_game_over;
    assign bus.busy      = r_busy;
    assign bus.length    = r_len;
    assign bus.head_x    = r_seg_x[0];
    assign bus.head_y    = r_seg_y[0];
endmodule
